// File: rtl/ps2_key_decoder.sv
// Receive-only PS/2 keyboard decoder: scan-code-set-2 frames to key_down/last_change/key_valid.
// Optional macro PS2_PARITY_CHECK_EN drops frames whose odd parity fails.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [127:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  localparam logic [7:0] ByteExt = 8'hE0;
  localparam logic [7:0] ByteBrk = 8'hF0;

  // Synchronisers
  logic clk_meta_q, clk_sync_q;
  logic data_meta_q, data_sync_q;

  // Clock filter
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall_q, fall_d;

  // Frame FSM
  logic [1:0]     state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           stop_q, stop_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           frame_ok;

  // Prefix tracking and outputs
  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic [127:0]   key_down_q, key_down_d;
  logic [8:0]     last_change_q, last_change_d;
  logic           key_valid_q, key_valid_d;

  // Idle PS/2 lines are high, so synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FiltMax) begin
        filt_d = clk_sync_q;
        fall_d = ~clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = stop_q & (^{shift_q, par_q});
`else
  assign frame_ok = stop_q;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stop_d    = stop_q;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fall_q && !data_sync_q) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      StShift: begin
        if (fall_q) begin
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8) begin
            shift_d = {data_sync_q, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            par_d = data_sync_q;
          end else begin
            stop_d  = data_sync_q;
            state_d = StCheck;
          end
        end else if (to_cnt_q == ToMax) begin
          state_d  = StIdle;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // A delivered byte is either a prefix or completes exactly one event.
  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    key_down_d    = key_down_q;
    last_change_d = last_change_q;
    key_valid_d   = 1'b0;
    if (state_q == StCheck) begin
      if (!frame_ok) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (shift_q == ByteExt) begin
        ext_d = 1'b1;
      end else if (shift_q == ByteBrk) begin
        brk_d = 1'b1;
      end else begin
        last_change_d = {ext_q, shift_q};
        key_valid_d   = 1'b1;
        if (!ext_q && !shift_q[7]) begin
          key_down_d[shift_q[6:0]] = ~brk_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      key_down_q    <= key_down_d;
      last_change_q <= last_change_d;
      key_valid_q   <= key_valid_d;
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder; follows PS2_PARITY_CHECK_EN if defined.
module tb_ps2_key_decoder;

  localparam int unsigned Filt = 4;
  localparam int unsigned Tmo  = 400;
  localparam int unsigned Half = 20;
  localparam int          Lat  = Filt + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;

  ps2_key_decoder #(
    .FILTER_LEN     (Filt),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Pulse monitor sampled on the falling edge
  int           pulses   = 0;
  int           doubles  = 0;
  int           lat      = -1;
  int           fall_cyc = 0;
  logic         prev_kv  = 1'b0;
  logic [127:0] kd_snap  = '0;
  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      lat     = cyc - fall_cyc;
      kd_snap = key_down;
      if (prev_kv) doubles++;
    end
    prev_kv = key_valid;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit is_stop);
    ps2_data = b;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) fall_cyc = cyc;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (3 * Half) @(negedge clk);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_key_down", key_down, '0);
    check("rst_last_change", {119'd0, last_change}, '0);
    check("rst_key_valid", {127'd0, key_valid}, '0);

    // Make A
    send_byte(8'h1C, 1'b0);
    check("make_pulses", pulses, 1);
    check("make_lc", {119'd0, last_change}, 128'h01C);
    check("make_kd", key_down, 128'd1 << 28);
    check("make_latency", lat, Lat);
    check("make_kd_same_edge", kd_snap, 128'd1 << 28);

    // Break A
    send_byte(8'hF0, 1'b0);
    check("f0_no_pulse", pulses, 1);
    send_byte(8'h1C, 1'b0);
    check("brk_pulses", pulses, 2);
    check("brk_lc", {119'd0, last_change}, 128'h01C);
    check("brk_kd", key_down, '0);

    // Extended make and break
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("ext_pulses", pulses, 3);
    check("ext_lc", {119'd0, last_change}, 128'h175);
    check("ext_kd", key_down, '0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("extbrk_pulses", pulses, 4);
    check("extbrk_lc", {119'd0, last_change}, 128'h175);
    send_byte(8'h75, 1'b0);
    check("ext_cleared_lc", {119'd0, last_change}, 128'h075);
    check("ext_cleared_kd", key_down, 128'd1 << 117);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("kp8_release_kd", key_down, '0);
    check("kp8_release_pulses", pulses, 6);

    // Bad parity
    send_byte(8'h29, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_pulses", pulses, 6);
    check("badpar_kd", key_down, '0);
`else
    check("badpar_pulses", pulses, 7);
    check("badpar_lc", {119'd0, last_change}, 128'h029);
    check("badpar_kd", key_down, 128'd1 << 41);
`endif

    // Partial frame abandoned by timeout
    base = pulses;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    repeat (Tmo + 10) @(negedge clk);
    check("tmo_no_pulse", pulses, base);
    send_byte(8'h29, 1'b0);
    check("tmo_pulses", pulses, base + 1);
    check("tmo_lc", {119'd0, last_change}, 128'h029);
    check("tmo_kd", key_down, 128'd1 << 41);

    // Reset during bit 4 of a 0x1C frame
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (Half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (Half / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_kd", key_down, '0);
    check("midrst_lc", {119'd0, last_change}, '0);
    check("midrst_kv", {127'd0, key_valid}, '0);
    repeat (Half / 2) @(negedge clk);
    ps2_clk = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    base = pulses;
    repeat (Tmo + 50) @(negedge clk);
    check("midrst_leftover_no_pulse", pulses, base);
    send_byte(8'h66, 1'b0);
    check("post_rst_pulses", pulses, base + 1);
    check("post_rst_lc", {119'd0, last_change}, 128'h066);
    check("post_rst_kd", key_down, 128'd1 << 102);
    check("post_rst_latency", lat, Lat);

    check("kv_single_cycle", doubles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receive-only PS/2 keyboard front end for the typing game. It deserialises scan-code-set-2 frames from the raw keyboard lines and tracks E0/F0 prefixes. It drives the `key_down` / `last_change` / `key_valid` interface that the game-logic counter consumes. It sits between the board PS/2 pins and every key-consuming block.

## Interface
- `FILTER_LEN`, 4: number of consecutive identical synchronised samples required before `ps2_clk` changes filtered level.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles allowed between falling edges inside a frame before the partial frame is discarded.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line (asynchronous).
- `ps2_data`  in  1  raw PS/2 data line (asynchronous).
- `key_down`  out  128  level map; bit i = 1 while non-extended make code i (0x00–0x7F) is held.
- `last_change`  out  9  {extended flag, scan byte} of the most recent complete make or break event.
- `key_valid`  out  1  one-cycle pulse per completed make or break event.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` pass through 2-flop synchronisers.
  - `ps2_clk` then passes through a FILTER_LEN-sample stable filter.
  - A filtered 1→0 transition is a "fall".
- Frame FSM states: IDLE, SHIFT, CHECK.
  - IDLE: a fall with `ps2_data`=0 (start bit) moves to SHIFT with bit count 0. A fall with data=1 is ignored.
  - SHIFT: each fall samples data, in order 8 data bits LSB-first, then odd parity, then stop. The stop-bit fall moves to CHECK.
  - CHECK, one cycle:
    - If stop=0, the frame is dropped.
    - If parity fails, the frame is dropped (see Configuration).
    - Otherwise the byte is delivered to the prefix FSM.
    - Returns to IDLE.
- Timeout: a counter runs in SHIFT and clears on each fall. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and the partial frame is dropped. Prefix flags are kept.
- Prefix FSM, per delivered byte:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte B is an event:
    - `last_change` = {ext, B}; `key_valid` pulses.
    - If ext=0 and B<0x80: `key_down[B[6:0]]` = ~brk.
    - Otherwise `key_down` is unchanged.
    - `ext` and `brk` clear.
- Typematic repeats: a make code for a key already down still pulses `key_valid`, and `key_down` stays 1. Repeat suppression belongs to consumers.
- A dropped frame (stop error, parity error) also clears `ext` and `brk`.
- Only one event can complete per frame, so no simultaneous events exist.

## Timing
- Reset values:
  - `key_down` = 0, `last_change` = 0, `key_valid` = 0.
  - FSM in IDLE, `ext` = `brk` = 0, counters 0.
- Reset asserted mid-frame: all state is cleared on that edge. Leftover bits of the frame are ignored until a start condition from IDLE; desync recovers via timeout.
- Fall detection: FILTER_LEN+2 cycles after a raw `ps2_clk` edge (sync plus filter).
- Event latency: `key_valid` is high exactly 2 `clk` cycles after the stop-bit fall (fall → CHECK → outputs registered).
- Output update: `key_down` and `last_change` take their new values on the same edge that raises `key_valid`. Consumers may index `key_down[last_change]` in the `key_valid` cycle.
- Pulse width: `key_valid` is high for exactly 1 cycle. It is never high on two consecutive cycles (frames are ≥11 falls apart).
- Prefix bytes (E0, F0) never pulse `key_valid`.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: frames with an even-parity total (8 data + parity) are dropped and prefix flags clear.
  - Undefined: the parity bit is sampled but ignored; only the stop-bit check and timeout apply.

## Test plan
- Make frame 0x1C (A) → 2 cycles after stop fall: `key_valid`=1 for 1 cycle, `last_change`=9'h01C, `key_down[28]`=1, all other bits 0.
- Frames F0, 1C after the above → a single `key_valid` pulse, `last_change`=9'h01C, `key_down[28]`=0; no pulse on the F0 byte.
- Frames E0, 75 → `key_valid` pulse, `last_change`=9'h175, `key_down` unchanged; E0, F0, 75 → `last_change`=9'h175, pulse, `ext` cleared afterwards.
- Frame 0x29 with a wrong parity bit:
  - With `PS2_PARITY_CHECK_EN`: no `key_valid` and `key_down[41]`=0.
  - Without it: a pulse occurs and `key_down[41]`=1.
- Start plus 5 data bits, then idle for TIMEOUT_CYCLES+10 cycles, then a full 0x29 frame → exactly one pulse, `last_change`=9'h029.
- `rst` high for 1 cycle during bit 4 of a 0x1C frame → all outputs 0. After the timeout, a clean 0x66 frame → pulse, `last_change`=9'h066, `key_down[102]`=1.
